iter_div_unit: RTL
==================

ITER_DIV_UNIT -- requirements
Module: iter_div_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request from EX stage; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port rs1  input  DATA_WIDTH  dividend.
REQ-007 SHALL have port rs2  input  DATA_WIDTH  divisor.
REQ-008 SHALL have port flush  input  1  abort in-flight operation (branch/exception squash).
REQ-009 SHALL have port busy  output  1  high while an accepted operation is incomplete; drives pipeline stall.
REQ-010 SHALL have port done  output  1  single-cycle pulse, result valid.
REQ-011 SHALL have port result  output  DATA_WIDTH  quotient or remainder per op; held until next acceptance.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-013 IDLE: start=1 and flush=0 SHALL latch op, operand magnitudes, sign flags; go to CALC, or to DONE for special cases (REQ-018/019).
REQ-014 CALC SHALL perform one restoring shift-subtract step per cycle on unsigned magnitudes, exactly DATA_WIDTH cycles, iteration counter 0..DATA_WIDTH-1.
REQ-015 FIX SHALL apply sign correction in one cycle: quotient negated if signed op and operand signs differ; remainder takes dividend sign; unsigned ops uncorrected.
REQ-016 DONE SHALL assert done=1 for one cycle, drive result, then return to IDLE.
REQ-017 Normal latency: start in cycle 0 -> done in cycle DATA_WIDTH+2 (34 for 32-bit); busy high cycles 1..DATA_WIDTH+1, low in done cycle.
REQ-018 Divide by zero SHALL bypass CALC: DIV/DIVU -> all ones; REM/REMU -> rs1; done in cycle 1.
REQ-019 Signed overflow (DIV/REM, rs1=most-negative, rs2=-1) SHALL bypass CALC: DIV -> most-negative, REM -> 0; done in cycle 1.
REQ-020 start while not IDLE SHALL be ignored; no queueing.
REQ-021 flush in any non-IDLE state SHALL return to IDLE next edge; done not asserted; result unchanged.
REQ-022 flush and start in same IDLE cycle: flush wins, nothing accepted.
REQ-023 start in the done cycle SHALL be ignored (state is DONE); accepted from the next IDLE cycle.
REQ-024 Operands SHALL be captured at acceptance; later rs1/rs2/op changes SHALL not affect the result.
REQ-025 Arithmetic width: partial remainder DATA_WIDTH+1 bits; magnitude of most-negative handled as unsigned 2^(DATA_WIDTH-1).

Reset
REQ-026 rst=1 SHALL force IDLE on the next edge, overriding start and flush, including mid-operation.
REQ-027 Reset values: busy=0, done=0, result=0, counter=0, latched operands=0.

Structure
REQ-028 Shared cpu package SHALL hold op encodings (DIV/DIVU/REM/REMU) and the FSM state enum.
REQ-029 One sub-module div_step SHALL be used: combinational single restoring iteration (partial remainder, divisor, quotient bit in; updated remainder, quotient bit out).
REQ-030 No divide operator SHALL be synthesized; only add/subtract/shift.

Verification
REQ-031 DIV 100/7 -> 14 in cycle 34; REM 100/7 -> 2; busy high cycles 1..33.
REQ-032 DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU -> 1.
REQ-033 DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, done in cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, done in cycle 1.
REQ-034 DIV 100/7, flush in cycle 10 -> busy low cycle 11, no done, result unchanged; new DIVU 9/4 -> 2 in 34 cycles.
REQ-035 rst asserted in cycle 20 of an operation -> busy=0, done=0, result=0 next cycle; start held during busy never queues a second done.

Source files
------------

// File: rtl/iter_div_unit_pkg.sv
// Shared definitions for the iterative divider: op encodings, FSM states
// and small op-decoding helpers used by the datapath and control.
package iter_div_unit_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/iter_div_unit_div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
// The next dividend bit is shifted into the partial remainder; if the
// divisor fits, it is subtracted and a quotient bit of 1 is produced.
module div_step
    import iter_div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH:0]   rem_in,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  bit_in,
    output logic [DATA_WIDTH:0]   rem_out,
    output logic                  q_bit
);

    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH+1:0] diff;

    // Trial subtraction with one spare bit so the borrow is visible; a set top
    // bit in the incoming remainder means the divisor certainly fits.
    always_comb begin
        shifted = {rem_in[DATA_WIDTH-1:0], bit_in};
        diff    = {1'b0, shifted} - {2'b00, divisor};
        q_bit   = rem_in[DATA_WIDTH] | ~diff[DATA_WIDTH+1];
        rem_out = q_bit ? diff[DATA_WIDTH:0] : shifted;
    end

endmodule

// File: rtl/iter_div_unit.sv
// Multi-cycle integer divider for the EX stage (DIV/DIVU/REM/REMU).
// Works on operand magnitudes with one restoring step per cycle, then fixes
// signs in a single cycle. Divide-by-zero and signed overflow skip the loop.
module iter_div_unit
    import iter_div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0]         LAST_STEP = CW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES  = '1;

    div_state_e            state;
    logic [CW-1:0]         count;
    div_op_e               op_q;
    logic [DATA_WIDTH:0]   rem_q;
    logic [DATA_WIDTH-1:0] quo_q;
    logic [DATA_WIDTH-1:0] divisor_q;
    logic                  neg_quo_q;
    logic                  neg_rem_q;

    div_op_e               op_in;
    logic                  in_signed;
    logic                  in_a_neg;
    logic                  in_b_neg;
    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH-1:0] b_mag;
    logic                  in_div_zero;
    logic                  in_overflow;
    logic [DATA_WIDTH-1:0] special_result;

    logic [DATA_WIDTH:0]   step_rem;
    logic                  step_q;

    logic [DATA_WIDTH-1:0] quo_fixed;
    logic [DATA_WIDTH-1:0] rem_fixed;
    logic [DATA_WIDTH-1:0] fix_result;

    // Decode the incoming request: sign flags, magnitudes and the two
    // shortcut cases. The most-negative value negates to itself, which is
    // exactly its unsigned magnitude.
    always_comb begin
        op_in       = div_op_e'(op);
        in_signed   = op_is_signed(op_in);
        in_a_neg    = in_signed & rs1[DATA_WIDTH-1];
        in_b_neg    = in_signed & rs2[DATA_WIDTH-1];
        a_mag       = in_a_neg ? (~rs1 + DATA_WIDTH'(1)) : rs1;
        b_mag       = in_b_neg ? (~rs2 + DATA_WIDTH'(1)) : rs2;
        in_div_zero = (rs2 == '0);
        in_overflow = in_signed && (rs1 == MOST_NEG) && (rs2 == ALL_ONES);
        if (in_div_zero) begin
            special_result = op_is_rem(op_in) ? rs1 : ALL_ONES;
        end else begin
            special_result = op_is_rem(op_in) ? '0 : MOST_NEG;
        end
    end

    // quo_q starts as the dividend magnitude; its MSB feeds each step while
    // quotient bits shift in at the bottom.
    div_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .rem_in (rem_q),
        .divisor(divisor_q),
        .bit_in (quo_q[DATA_WIDTH-1]),
        .rem_out(step_rem),
        .q_bit  (step_q)
    );

    // Sign correction applied at the end of the loop.
    always_comb begin
        quo_fixed  = neg_quo_q ? (~quo_q + DATA_WIDTH'(1)) : quo_q;
        rem_fixed  = neg_rem_q ? (~rem_q[DATA_WIDTH-1:0] + DATA_WIDTH'(1))
                               : rem_q[DATA_WIDTH-1:0];
        fix_result = op_is_rem(op_q) ? rem_fixed : quo_fixed;
    end

    // Control FSM with registered busy/done/result; reset beats flush,
    // flush beats everything else outside IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            op_q      <= OP_DIV;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else if (flush && (state != IDLE)) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !flush) begin
                        op_q      <= op_in;
                        rem_q     <= '0;
                        quo_q     <= a_mag;
                        divisor_q <= b_mag;
                        neg_quo_q <= in_a_neg ^ in_b_neg;
                        neg_rem_q <= in_a_neg;
                        count     <= '0;
                        if (in_div_zero || in_overflow) begin
                            result <= special_result;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[DATA_WIDTH-2:0], step_q};
                    if (count == LAST_STEP) begin
                        count <= '0;
                        state <= FIX;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                FIX: begin
                    result <= fix_result;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
